// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, fetch FSM states and the byte-swap helper
// that is also used by the load path.
package cpu_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   function automatic logic [WORD_W-1:0] byte_swap32(input logic [WORD_W-1:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO of {inst, pc} entries with push/pop/clear and an occupancy count.
// Storage is not reset; only pointers and count are.
module inst_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign count = count_q;

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch: sequential word fetch, optional byte swap, FIFO buffering
// and flush redirect. Optional statistics counters under PREFETCH_STATS_EN.
module prefetch_unit
   import cpu_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    little_endian_en,
   output logic [WORD_W-1:0]       mem_address,
   output logic                    mem_read,
   input  logic [WORD_W-1:0]       mem_data_in,
   input  logic                    mem_ready,
   output logic                    inst_valid,
   output logic [WORD_W-1:0]       inst,
   output logic [WORD_W-1:0]       inst_pc,
   input  logic                    inst_ready,
   input  logic                    flush,
   input  logic [WORD_W-1:0]       flush_pc,
   output logic [$clog2(DEPTH):0]  fifo_count
`ifdef PREFETCH_STATS_EN
   ,
   output logic [31:0]             stat_fetched,
   output logic [31:0]             stat_discarded
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t      state;
   logic [WORD_W-1:0] fetch_pc;
   logic [WORD_W-1:0] flush_target;
   logic [WORD_W-1:0] next_pc;
   logic [WORD_W-1:0] fetch_word;
   logic [63:0]       fifo_dout;
   logic [CW-1:0]     count_next;
   logic              push;
   logic              pop;
   logic              space_next;
   logic              unused_flush_lsbs;

   assign flush_target      = {flush_pc[31:2], 2'b00};
   assign unused_flush_lsbs = ^flush_pc[1:0];
   assign next_pc           = fetch_pc + 32'd4;
   assign fetch_word        = little_endian_en ? byte_swap32(mem_data_in) : mem_data_in;

   assign push       = (state == FETCH) && mem_read && mem_ready && !flush;
   assign pop        = inst_valid && inst_ready && !flush;
   assign count_next = fifo_count + CW'(push) - CW'(pop);
   // A request raised now is visible next cycle, so judge space on next-cycle occupancy.
   assign space_next = count_next < CW'(DEPTH);

   inst_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (64)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .clear (flush),
      .din   ({fetch_word, fetch_pc}),
      .dout  (fifo_dout),
      .count (fifo_count)
   );

   assign inst_valid = (fifo_count != '0);
   assign inst       = inst_valid ? fifo_dout[63:32] : '0;
   assign inst_pc    = inst_valid ? fifo_dout[31:0]  : '0;

   // In DISCARD, fetch_pc holds the redirect target while the cancelled request drains.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         mem_read    <= 1'b0;
         mem_address <= RESET_PC;
         fetch_pc    <= RESET_PC;
      end else begin
         unique case (state)
            IDLE: begin
               state       <= FETCH;
               mem_read    <= 1'b1;
               mem_address <= flush ? flush_target : fetch_pc;
               if (flush) fetch_pc <= flush_target;
            end
            FETCH: begin
               if (flush) begin
                  fetch_pc <= flush_target;
                  if (mem_read && !mem_ready) begin
                     state <= DISCARD;
                  end else begin
                     mem_read    <= 1'b1;
                     mem_address <= flush_target;
                  end
               end else if (mem_read && mem_ready) begin
                  fetch_pc    <= next_pc;
                  mem_read    <= space_next;
                  mem_address <= next_pc;
               end else if (!mem_read && space_next) begin
                  mem_read    <= 1'b1;
                  mem_address <= fetch_pc;
               end
            end
            DISCARD: begin
               if (flush) fetch_pc <= flush_target;
               if (mem_ready) begin
                  state       <= FETCH;
                  mem_address <= flush ? flush_target : fetch_pc;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PREFETCH_STATS_EN
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   logic resp_drop;
   assign resp_drop = mem_read && mem_ready && (flush || (state == DISCARD));

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_fetched   <= '0;
         stat_discarded <= '0;
      end else begin
         stat_fetched   <= sat_add(stat_fetched, {31'b0, push});
         stat_discarded <= sat_add(stat_discarded,
                                   (flush ? 32'(fifo_count) : 32'd0) + {31'b0, resp_drop});
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the fetched instruction stream.
module tb_prefetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic                   little_endian_en = 1'b0;
   logic                   mem_ready = 1'b0;
   logic                   inst_ready = 1'b0;
   logic                   flush = 1'b0;
   logic [31:0]            flush_pc = '0;
   logic [31:0]            mem_address;
   logic [31:0]            mem_data_in;
   logic [31:0]            inst;
   logic [31:0]            inst_pc;
   logic                   mem_read;
   logic                   inst_valid;
   logic [$clog2(DEPTH):0] fifo_count;
`ifdef PREFETCH_STATS_EN
   logic [31:0]            stat_fetched;
   logic [31:0]            stat_discarded;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int n_pops   = 0;

   always #5 clk = ~clk;

   prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk              (clk),
      .reset            (reset),
      .little_endian_en (little_endian_en),
      .mem_address      (mem_address),
      .mem_read         (mem_read),
      .mem_data_in      (mem_data_in),
      .mem_ready        (mem_ready),
      .inst_valid       (inst_valid),
      .inst             (inst),
      .inst_pc          (inst_pc),
      .inst_ready       (inst_ready),
      .flush            (flush),
      .flush_pc         (flush_pc),
      .fifo_count       (fifo_count)
`ifdef PREFETCH_STATS_EN
      ,
      .stat_fetched     (stat_fetched),
      .stat_discarded   (stat_discarded)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0)  return 32'hE3A0_0001;
      if (a == 32'h40) return 32'h0100_A0E3;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   function automatic logic [31:0] swap_bytes(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   assign mem_data_in = mem_word(mem_address);

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic drive_step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_flush(input logic [31:0] pc);
      flush    = 1'b1;
      flush_pc = pc;
      drive_step();
      flush    = 1'b0;
   endtask

   task automatic wait_valid(input string tag, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         if (inst_valid) ok = 1'b1;
      end
      if (!ok) chk({tag, "_timeout"}, 0, 1);
   endtask

   // Reference model: expected buffer contents and next fetch address
   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } ent_t;

   ent_t        q[$];
   logic [31:0] m_fpc      = RESET_PC;
   bit          m_cancel   = 1'b0;
   bit          prev_pend  = 1'b0;
   bit          prev_read  = 1'b0;
   logic [31:0] prev_addr  = '0;
   bit          m_pop;
   logic [31:0] m_word;

   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         m_fpc     = RESET_PC;
         m_cancel  = 1'b0;
         prev_pend = 1'b0;
         prev_read = 1'b0;
      end else begin
         chk("valid", inst_valid, q.size() != 0);
         chk("count", fifo_count, q.size());
         if (q.size() != 0) begin
            chk("inst", inst, q[0].data);
            chk("inst_pc", inst_pc, q[0].pc);
         end
         if (prev_pend) begin
            chk("hold_rd", mem_read, 1);
            chk("hold_addr", mem_address, prev_addr);
         end
         if (mem_read && !prev_read) chk("start_space", q.size() < DEPTH, 1);
         if (flush) begin
            q.delete();
            m_fpc    = {flush_pc[31:2], 2'b00};
            m_cancel = mem_read && !mem_ready;
         end else begin
            m_pop = (q.size() != 0) && inst_ready;
            if (m_pop) begin
               void'(q.pop_front());
               n_pops++;
            end
            if (mem_read && mem_ready && !m_cancel) begin
               chk("fetch_addr", mem_address, m_fpc);
               m_word = little_endian_en ? swap_bytes(mem_word(m_fpc)) : mem_word(m_fpc);
               q.push_back('{pc: m_fpc, data: m_word});
               m_fpc = m_fpc + 32'd4;
            end
            if (mem_ready) m_cancel = 1'b0;
         end
         prev_pend = mem_read && !mem_ready;
         prev_addr = mem_address;
         prev_read = mem_read;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
      $fatal(1);
   end

   initial begin
      bit ok;
      int got;

      repeat (3) drive_step();
      @(negedge clk);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_addr", mem_address, RESET_PC);
      chk("rst_valid", inst_valid, 0);
      chk("rst_inst", inst, 0);
      chk("rst_inst_pc", inst_pc, 0);
      chk("rst_count", fifo_count, 0);

      // Reset release with zero-wait memory, CPU not consuming
      drive_step();
      reset     = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("first_rd", mem_read, 1);
      chk("first_addr", mem_address, 32'h0);
      @(negedge clk);
      chk("first_valid", inst_valid, 1);
      chk("first_inst", inst, 32'hE3A0_0001);
      chk("first_pc", inst_pc, 32'h0);
      repeat (6) @(negedge clk);
      chk("full_rd", mem_read, 0);
      chk("full_count", fifo_count, 4);

      drive_step();
      inst_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && got < 5; c++) begin
         @(negedge clk);
         if (inst_valid && inst_ready) begin
            chk($sformatf("drain_pc%0d", got), inst_pc, got * 4);
            got++;
         end
      end
      if (got < 5) chk("drain_timeout", got, 5);

      // Little-endian conversion
      drive_step();
      inst_ready       = 1'b0;
      little_endian_en = 1'b1;
      pulse_flush(32'h40);
      wait_valid("le", ok);
      if (ok) begin
         chk("le_inst", inst, 32'hE3A0_0001);
         chk("le_pc", inst_pc, 32'h40);
      end

      // Stall on 0x8 with a flush in the first stall cycle
      drive_step();
      little_endian_en = 1'b0;
      inst_ready       = 1'b1;
      mem_ready        = 1'b1;
      pulse_flush(32'h0);
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         if (mem_read && mem_address == 32'h8) ok = 1'b1;
         else drive_step();
      end
      if (!ok) chk("stall_reach_timeout", 0, 1);
      mem_ready = 1'b0;
      flush     = 1'b1;
      flush_pc  = 32'h103;
      drive_step();
      flush = 1'b0;
      chk("stall_addr2", mem_address, 32'h8);
      chk("stall_rd2", mem_read, 1);
      drive_step();
      chk("stall_addr3", mem_address, 32'h8);
      drive_step();
      chk("stall_addr4", mem_address, 32'h8);
      mem_ready = 1'b1;
      drive_step();
      chk("redir_addr", mem_address, 32'h100);
      chk("redir_rd", mem_read, 1);
      wait_valid("redir", ok);
      if (ok) chk("redir_pc", inst_pc, 32'h100);

      // Flush together with a pop and a memory completion
      drive_step();
      inst_ready = 1'b0;
      mem_ready  = 1'b1;
      pulse_flush(32'h180);
      drive_step();
      chk("coin_pre_valid", inst_valid, 1);
      chk("coin_pre_rd", mem_read, 1);
      inst_ready = 1'b1;
      flush      = 1'b1;
      flush_pc   = 32'h200;
      drive_step();
      flush      = 1'b0;
      @(negedge clk);
      chk("coin_valid", inst_valid, 0);
      chk("coin_count", fifo_count, 0);
      wait_valid("coin", ok);
      if (ok) begin
         chk("coin_pc", inst_pc, 32'h200);
         chk("coin_inst", inst, mem_word(32'h200));
      end

      // Address wrap at the top of the address space
      drive_step();
      inst_ready = 1'b1;
      mem_ready  = 1'b1;
      pulse_flush(32'hFFFF_FFFE);
      chk("wrap_addr0", mem_address, 32'hFFFF_FFFC);
      drive_step();
      chk("wrap_addr1", mem_address, 32'h0);

      // Randomized traffic, including a reset in the middle
      for (int c = 0; c < 3000; c++) begin
         drive_step();
         mem_ready        = ($urandom_range(0, 2) != 0);
         inst_ready       = ($urandom_range(0, 3) != 0);
         little_endian_en = $urandom_range(0, 1);
         flush            = ($urandom_range(0, 29) == 0);
         flush_pc         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                        : $urandom;
         reset            = (c >= 1500 && c < 1502);
      end
      drive_step();
      flush = 1'b0;
      reset = 1'b0;
      chk("rand_progress", n_pops > 300, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/prefetch_unit.md
Name: prefetch_unit

Overview:
- Instruction prefetch stage sitting directly upstream of the CPU's decode/execute datapath.
- Issues sequential word reads to memory and converts little-endian words to the CPU's big-endian instruction convention.
- Buffers instructions with their PCs in a small FIFO and hands them to the CPU over a valid/ready handshake.
- A redirect (branch/flush) input discards buffered and in-flight instructions and restarts fetch at a new PC.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset; word aligned.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- little_endian_en  input  1  when 1, byte-reverse each fetched word before buffering.
- mem_address  output  32  fetch address, word aligned.
- mem_read  output  1  read request; held until mem_ready.
- mem_data_in  input  32  read data; valid when mem_read && mem_ready.
- mem_ready  input  1  completes the current request this cycle.
- inst_valid  output  1  inst/inst_pc hold a valid entry.
- inst  output  32  instruction at FIFO head.
- inst_pc  output  32  address of inst.
- inst_ready  input  1  CPU consumes the head entry when inst_valid && inst_ready.
- flush  input  1  redirect request, single-cycle pulse.
- flush_pc  input  32  redirect target; bits [1:0] ignored, forced to 0.
- fifo_count  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset:
  - mem_read=0, mem_address=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fifo_count=0.
  - fetch_pc=RESET_PC, state=IDLE.
  - Reset mid-request drops the request with no response handling.
- States:
  - IDLE: next cycle goes to FETCH unconditionally.
  - FETCH: normal fetching.
  - DISCARD: waits out an in-flight request that a flush has cancelled.
- FETCH request rules:
  - A new request starts only when fifo_count < DEPTH: mem_read=1, mem_address=fetch_pc.
  - Once started, mem_read and mem_address stay stable until mem_ready, even if the FIFO fills meanwhile. Space is guaranteed because there is one outstanding request at most.
- FETCH completion (mem_read && mem_ready):
  - Push {swap(mem_data_in), fetch_pc}; swap is applied when little_endian_en=1, sampled that cycle.
  - fetch_pc += 4, wrapping modulo 2^32.
  - A next request may start the following cycle, so back-to-back throughput is 1 word per cycle when memory is zero-wait.
- Latency: minimum 1 cycle from mem_ready to inst_valid=1 (registered FIFO).
- Pop: on inst_valid && inst_ready, the head advances.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Pop with count=0 is impossible, because inst_valid = (count != 0).
- Full: count=DEPTH means no new request; an outstanding request still completes and pushes.
- Flush priority: flush beats pop and push in the same cycle.
  - FIFO is cleared, so the next cycle has inst_valid=0 and count=0.
  - fetch_pc = {flush_pc[31:2],2'b00}.
- Flush with no outstanding request: go to or stay in FETCH; a request to the new PC may start next cycle.
- Flush in the same cycle as mem_ready: response discarded; stay in FETCH.
- Flush while mem_read=1 and mem_ready=0: enter DISCARD.
  - Keep mem_read=1 and the old mem_address until mem_ready.
  - Drop the returned data, then return to FETCH with the stored target.
- Flush while in DISCARD: replace the stored target with the newest flush_pc.
- FIFO pointers wrap modulo DEPTH; the count distinguishes full from empty.

Optional Feature:
- Macro PREFETCH_STATS_EN.
- Defined:
  - Adds outputs stat_fetched[31:0] (count of pushes) and stat_discarded[31:0] (flushed FIFO entries plus dropped in-flight responses).
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - WORD_W=32.
  - Fetch state enum {IDLE, FETCH, DISCARD}.
  - Function byte_swap32, shared with the CPU's load path.
- One sub-module, inst_fifo: synchronous FIFO of {inst,pc}, with DEPTH and WIDTH=64 parameters, push/pop/clear and count.

Test Plan:
- Reset release with zero-wait memory returning 32'hE3A0_0001 at 0x0, little_endian_en=0:
  - mem_read=1 and address=0x0 on the first cycle.
  - Next cycle inst_valid=1, inst=E3A00001, inst_pc=0.
- little_endian_en=1, memory word 32'h0100_A0E3 → inst=32'hE3A0_0001.
- inst_ready=0 held with zero-wait memory:
  - Exactly 4 words are fetched at addresses 0x0–0xC; mem_read drops and fifo_count=4.
  - Raising inst_ready yields PCs 0,4,8,C in order, then fetching resumes at 0x10.
- Memory stalls 3 cycles on address 0x8; flush with flush_pc=0x103 in stall cycle 1:
  - Address stays at 0x8 until mem_ready and the data is dropped.
  - Next request address=0x100; first inst_pc=0x100.
- Flush coinciding with a pop and with mem_ready:
  - FIFO empties; neither the popped entry nor the returned word reappears.
  - Fetch continues from flush_pc.
- fetch_pc=0xFFFF_FFFC → next request address wraps to 0x0000_0000.
